id_stage: RTL and testbench

Instruction decode stage of the RV32I pipeline, directly downstream of instruction fetch. Each cycle it takes the fetched PC and instruction word, decodes them, reads two source operands from the integer register file it owns, and generates the sign-extended immediate. Results are registered into the ID/EX pipeline register. It also accepts the single writeback port from the final stage, and supports stall and flush from hazard and branch logic.

---
 rtl/rv32i_pkg.sv | 74 +++++++
 rtl/regfile_2r1w.sv | 46 ++++
 rtl/id_stage.sv | 170 +++++++++++++++++
 tb/tb_id_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU operation codes, NOP encoding,
// and the funct3-to-ALU-op helper used by the decoder.
package rv32i_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   // ID/EX pipeline register contents
   typedef struct packed {
      logic          valid;
      logic [31:0]   pc;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [4:0]    rd;
      logic [31:0]   rs1_data;
      logic [31:0]   rs2_data;
      logic [31:0]   imm;
      alu_op_e       alu_op;
      logic          alu_src_imm;
      logic          alu_src_pc;
      logic [2:0]    funct3;
      logic          reg_we;
      logic          mem_re;
      logic          mem_we;
      logic          branch;
      logic          jal;
      logic          jalr;
      logic          illegal;
   } idex_t;

   // alt selects SUB over ADD and SRA over SRL (instr[30]); the caller
   // decides whether alt is meaningful for funct3=000.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 integer register file, 2 combinational read ports, 1 write port.
// x0 reads as zero and ignores writes; all entries clear on reset.
// Optional macro ID_WB_BYPASS_EN: a read of the register being written in
// the same cycle returns the incoming write data.
module regfile_2r1w
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0][31:0] regs;
   logic              wr_live;

   assign wr_live = we && (waddr != 5'd0);

   // Write port; x0 is never written so it stays at its reset value of 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) regs <= '0;
      else if (wr_live) regs[waddr] <= wdata;
   end

   function automatic logic [31:0] rd_port(input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0) v = 32'h0;
`ifdef ID_WB_BYPASS_EN
      else if (wr_live && (a == waddr)) v = wdata;
`endif
      else v = regs[a];
      return v;
   endfunction

   // Read ports
   always_comb begin
      rdata1 = rd_port(raddr1);
      rdata2 = rd_port(raddr2);
   end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: combinational decode of the fetched word,
// register-file read, immediate generation, and the ID/EX register with
// flush/stall handling. Optional macro ID_WB_BYPASS_EN (in regfile_2r1w)
// forwards same-cycle writeback data to the operand reads.
module id_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic [31:0] if_instr,
   input  logic        stall,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [4:0]  id_rd,
   output logic [31:0] id_rs1_data,
   output logic [31:0] id_rs2_data,
   output logic [31:0] id_imm,
   output logic [3:0]  id_alu_op,
   output logic        id_alu_src_imm,
   output logic        id_alu_src_pc,
   output logic [2:0]  id_funct3,
   output logic        id_reg_we,
   output logic        id_mem_re,
   output logic        id_mem_we,
   output logic        id_branch,
   output logic        id_jal,
   output logic        id_jalr,
   output logic        id_illegal
);

   logic [31:0] rd1, rd2;
   idex_t       dec, idex;

   regfile_2r1w u_rf (
      .clk    (clk),
      .reset  (reset),
      .raddr1 (if_instr[19:15]),
      .raddr2 (if_instr[24:20]),
      .rdata1 (rd1),
      .rdata2 (rd2),
      .we     (wb_we),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = if_instr[6:0];
   assign f3     = if_instr[14:12];
   assign f7     = if_instr[31:25];
   assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u  = {if_instr[31:12], 12'h000};
   assign imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

   // Decode the fetched word into a candidate ID/EX entry. Opcodes without
   // an immediate (OP, FENCE, SYSTEM, illegal) carry imm=0.
   always_comb begin
      dec          = '0;
      dec.alu_op   = ALU_ADD;
      dec.valid    = 1'b1;
      dec.pc       = if_pc;
      dec.rs1      = if_instr[19:15];
      dec.rs2      = if_instr[24:20];
      dec.rd       = if_instr[11:7];
      dec.funct3   = f3;
      dec.rs1_data = rd1;
      dec.rs2_data = rd2;
      case (opcode)
         LUI: begin
            dec.imm = imm_u; dec.alu_op = ALU_PASSB;
            dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
         end
         AUIPC: begin
            dec.imm = imm_u; dec.alu_src_pc = 1'b1;
            dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
         end
         JAL: begin
            dec.imm = imm_j; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
            dec.reg_we = 1'b1; dec.jal = 1'b1;
         end
         JALR: begin
            dec.imm = imm_i; dec.alu_src_pc = 1'b1; dec.alu_src_imm = 1'b1;
            dec.reg_we = 1'b1; dec.jalr = 1'b1;
         end
         BRANCH: begin
            dec.imm = imm_b; dec.branch = 1'b1;
         end
         LOAD: begin
            dec.imm = imm_i; dec.alu_src_imm = 1'b1;
            dec.reg_we = 1'b1; dec.mem_re = 1'b1;
         end
         STORE: begin
            dec.imm = imm_s; dec.alu_src_imm = 1'b1; dec.mem_we = 1'b1;
         end
         OP_IMM: begin
            dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
            // instr[30] only distinguishes SRAI; for ADDI it is immediate data
            dec.alu_op = alu_from_funct3(f3, (f3 == 3'b101) && if_instr[30]);
            dec.illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
         end
         OP: begin
            dec.reg_we = 1'b1;
            dec.alu_op = alu_from_funct3(f3, if_instr[30]);
            dec.illegal = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         FENCE, SYSTEM: ;
         default: dec.illegal = 1'b1;
      endcase
      // An illegal instruction must not change architectural state
      if (dec.illegal) begin
         dec.reg_we = 1'b0;
         dec.mem_re = 1'b0;
         dec.mem_we = 1'b0;
      end
   end

   // ID/EX register: reset > flush > stall (hold, refresh operands) > load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex    <= '0;
         idex.pc <= RESET_PC;
      end else if (flush) begin
         idex <= '0;
      end else if (stall) begin
         if (wb_we && (wb_rd != 5'd0) && (wb_rd == idex.rs1)) idex.rs1_data <= wb_data;
         if (wb_we && (wb_rd != 5'd0) && (wb_rd == idex.rs2)) idex.rs2_data <= wb_data;
      end else if (if_valid) begin
         idex <= dec;
      end else begin
         idex <= '0;
      end
   end

   assign id_valid       = idex.valid;
   assign id_pc          = idex.pc;
   assign id_rs1         = idex.rs1;
   assign id_rs2         = idex.rs2;
   assign id_rd          = idex.rd;
   assign id_rs1_data    = idex.rs1_data;
   assign id_rs2_data    = idex.rs2_data;
   assign id_imm         = idex.imm;
   assign id_alu_op      = idex.alu_op;
   assign id_alu_src_imm = idex.alu_src_imm;
   assign id_alu_src_pc  = idex.alu_src_pc;
   assign id_funct3      = idex.funct3;
   assign id_reg_we      = idex.reg_we;
   assign id_mem_re      = idex.mem_re;
   assign id_mem_we      = idex.mem_we;
   assign id_branch      = idex.branch;
   assign id_jal         = idex.jal;
   assign id_jalr        = idex.jalr;
   assign id_illegal     = idex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: an instruction-level reference model updated each
// clock, a per-cycle compare process, and literal spot checks.
module tb_id_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset, if_valid, stall, flush, wb_we;
   logic [31:0] if_pc, if_instr, wb_data;
   logic [4:0]  wb_rd;
   logic        id_valid, id_alu_src_imm, id_alu_src_pc, id_reg_we, id_mem_re, id_mem_we;
   logic        id_branch, id_jal, id_jalr, id_illegal;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;
   logic [2:0]  id_funct3;

   id_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
      .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
      .id_funct3(id_funct3), .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
      .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr), .id_illegal(id_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  op;
      logic        simm, spc, we, re, mw, br, jal, jalr, ill;
      logic [2:0]  f3;
   } exp_t;

   exp_t        m;
   logic [31:0] mrf [32];
   logic [31:0] mr1, mr2;
   logic [3:0]  f3_op [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
   int          vectors = 0, miscompares = 0;
   bit          checking = 0;

   function automatic exp_t bubble();
      exp_t e;
      e.valid = 0; e.pc = 0; e.d1 = 0; e.d2 = 0; e.imm = 0;
      e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.op = 0; e.f3 = 0;
      e.simm = 0; e.spc = 0; e.we = 0; e.re = 0; e.mw = 0;
      e.br = 0; e.jal = 0; e.jalr = 0; e.ill = 0;
      return e;
   endfunction

   // Reference decode by instruction class
   function automatic exp_t model_decode(input logic [31:0] pc, ins, d1, d2);
      exp_t        e = bubble();
      logic [6:0]  f7 = ins[31:25];
      logic [2:0]  f3 = ins[14:12];
      logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      i_imm = 32'($signed(ins) >>> 20);
      s_imm = {i_imm[31:5], ins[11:7]};
      b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      u_imm = ins & 32'hFFFF_F000;
      j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      e.valid = 1; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.f3 = f3; e.d1 = d1; e.d2 = d2;
      case (ins[6:0])
         7'h37: begin e.imm = u_imm; e.op = 4'd10; e.simm = 1; e.we = 1; end
         7'h17: begin e.imm = u_imm; e.spc = 1; e.simm = 1; e.we = 1; end
         7'h6F: begin e.imm = j_imm; e.spc = 1; e.simm = 1; e.we = 1; e.jal = 1; end
         7'h67: begin e.imm = i_imm; e.spc = 1; e.simm = 1; e.we = 1; e.jalr = 1; end
         7'h63: begin e.imm = b_imm; e.br = 1; end
         7'h03: begin e.imm = i_imm; e.simm = 1; e.we = 1; e.re = 1; end
         7'h23: begin e.imm = s_imm; e.simm = 1; e.mw = 1; end
         7'h13: begin
            e.imm = i_imm; e.simm = 1; e.we = 1;
            e.op = f3_op[f3] + ((ins[30] && f3 == 3'd5) ? 4'd1 : 4'd0);
            if (f3 == 3'd1) e.ill = (f7 != 0);
            if (f3 == 3'd5) e.ill = !(f7 == 0 || f7 == 7'h20);
         end
         7'h33: begin
            e.we = 1;
            e.op = f3_op[f3] + ((ins[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
            e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'h0F, 7'h73: ;
         default: e.ill = 1;
      endcase
      if (e.ill) begin e.we = 0; e.re = 0; e.mw = 0; end
      return e;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] ix);
      if (ix == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
      if (wb_we && wb_rd == ix) return wb_data;
`endif
      return mrf[ix];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m = bubble(); m.pc = RST_PC;
         for (int i = 0; i < 32; i++) mrf[i] = 0;
      end else begin
         mr1 = model_read(if_instr[19:15]);
         mr2 = model_read(if_instr[24:20]);
         if (flush) m = bubble();
         else if (stall) begin
            if (wb_we && wb_rd != 0 && wb_rd == m.rs1) m.d1 = wb_data;
            if (wb_we && wb_rd != 0 && wb_rd == m.rs2) m.d2 = wb_data;
         end
         else if (if_valid) m = model_decode(if_pc, if_instr, mr1, mr2);
         else m = bubble();
         if (wb_we && wb_rd != 0) mrf[wb_rd] = wb_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      if (checking) begin
         chk("valid", 32'(id_valid), 32'(m.valid));
         chk("pc", id_pc, m.pc);
         chk("rs1", 32'(id_rs1), 32'(m.rs1));
         chk("rs2", 32'(id_rs2), 32'(m.rs2));
         chk("rd", 32'(id_rd), 32'(m.rd));
         chk("rs1_data", id_rs1_data, m.d1);
         chk("rs2_data", id_rs2_data, m.d2);
         chk("imm", id_imm, m.imm);
         chk("alu_op", 32'(id_alu_op), 32'(m.op));
         chk("src_imm", 32'(id_alu_src_imm), 32'(m.simm));
         chk("src_pc", 32'(id_alu_src_pc), 32'(m.spc));
         chk("funct3", 32'(id_funct3), 32'(m.f3));
         chk("reg_we", 32'(id_reg_we), 32'(m.we));
         chk("mem_re", 32'(id_mem_re), 32'(m.re));
         chk("mem_we", 32'(id_mem_we), 32'(m.mw));
         chk("branch", 32'(id_branch), 32'(m.br));
         chk("jal", 32'(id_jal), 32'(m.jal));
         chk("jalr", 32'(id_jalr), 32'(m.jalr));
         chk("illegal", 32'(id_illegal), 32'(m.ill));
      end
   end

   task automatic apply(input logic v, input logic [31:0] pc, ins, input logic st, fl,
                        input logic we, input logic [4:0] rd, input logic [31:0] d);
      if_valid = v; if_pc = pc; if_instr = ins; stall = st; flush = fl;
      wb_we = we; wb_rd = rd; wb_data = d;
      @(posedge clk);
      #2;
   endtask

   logic [31:0] tbl [12] = '{
      32'h40530533, 32'h40335593, 32'h40331593, 32'hABCDE637,
      32'h00001697, 32'hFF9FF0EF, 32'h00008067, 32'h00512423,
      32'h0FF0000F, 32'h00000073, 32'h0072E733, 32'h02528333
   };

   initial begin
      reset = 1; if_valid = 0; if_pc = 0; if_instr = 0; stall = 0; flush = 0;
      wb_we = 0; wb_rd = 0; wb_data = 0;
      #3;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_pc", id_pc, RST_PC);
      chk("rst_alu_op", 32'(id_alu_op), 32'd0);
      chk("rst_reg_we", 32'(id_reg_we), 32'd0);
      reset = 0;
      checking = 1;

      apply(1, 32'h100, 32'h0000_0013, 0, 0, 0, 0, 0);
      chk("nop_valid", 32'(id_valid), 32'd1);
      chk("nop_alu_op", 32'(id_alu_op), 32'd0);
      chk("nop_src_imm", 32'(id_alu_src_imm), 32'd1);
      chk("nop_reg_we", 32'(id_reg_we), 32'd1);
      chk("nop_rd", 32'(id_rd), 32'd0);
      chk("nop_imm", id_imm, 32'd0);

      apply(0, 0, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
      apply(0, 0, 32'h1234_0000, 0, 0, 1, 5'd7, 32'hAAAA_0000);
      chk("bubble_valid", 32'(id_valid), 32'd0);
      apply(1, 32'h104, 32'h00528333, 0, 0, 0, 0, 0);
      chk("add_rs1_data", id_rs1_data, 32'hDEAD_BEEF);
      chk("add_rs2_data", id_rs2_data, 32'hDEAD_BEEF);
      chk("add_rd", 32'(id_rd), 32'd6);

      apply(1, 32'h108, 32'hFE000EE3, 0, 0, 0, 0, 0);
      chk("beq_imm", id_imm, 32'hFFFF_FFFC);
      chk("beq_branch", 32'(id_branch), 32'd1);
      chk("beq_reg_we", 32'(id_reg_we), 32'd0);
      chk("beq_funct3", 32'(id_funct3), 32'd0);

      apply(1, 32'h10C, 32'h00038413, 0, 0, 1, 5'd7, 32'h1234_5678);
`ifdef ID_WB_BYPASS_EN
      chk("addi_bypass", id_rs1_data, 32'h1234_5678);
`else
      chk("addi_nobypass", id_rs1_data, 32'hAAAA_0000);
`endif

      apply(1, 32'h110, 32'h0042A483, 0, 0, 0, 0, 0);
      chk("lw_mem_re", 32'(id_mem_re), 32'd1);
      chk("lw_imm", id_imm, 32'd4);
      apply(1, 32'h114, 32'h0000_0013, 1, 0, 1, 5'd5, 32'h0000_0055);
      chk("stall_pc", id_pc, 32'h110);
      chk("stall_mem_re", 32'(id_mem_re), 32'd1);
      chk("stall_refresh", id_rs1_data, 32'h0000_0055);
      apply(1, 32'h118, 32'h0042A483, 1, 1, 0, 0, 0);
      chk("flush_valid", 32'(id_valid), 32'd0);
      chk("flush_mem_re", 32'(id_mem_re), 32'd0);

      apply(1, 32'h11C, 32'h0000_007F, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
      chk("ill_flag", 32'(id_illegal), 32'd1);
      chk("ill_reg_we", 32'(id_reg_we), 32'd0);
      chk("ill_valid", 32'(id_valid), 32'd1);
      apply(1, 32'h120, 32'h000000B3, 0, 0, 0, 0, 0);
      chk("x0_read", id_rs1_data, 32'd0);

      for (int i = 0; i < 12; i++) begin
         apply(1, 32'h200 + 32'(4 * i), tbl[i], 0, 0, (i % 3) == 0, 5'(i + 2), 32'hC0DE_0000 + 32'(i));
         if (i == 3) begin
            chk("lui_imm", id_imm, 32'hABCD_E000);
            chk("lui_alu_op", 32'(id_alu_op), 32'd10);
         end
         if (i == 5) chk("jal_imm", id_imm, 32'hFFFF_FFF8);
         if (i == 11) chk("mul_illegal", 32'(id_illegal), 32'd1);
      end
      apply(1, 32'h300, 32'h00528333, 1, 0, 1, 5'd5, 32'h0BAD_F00D);
      apply(1, 32'h304, 32'h00528333, 1, 0, 1, 5'd5, 32'h1111_2222);
      chk("stall_rs2_refresh", id_rs2_data, 32'h1111_2222);
      apply(0, 32'h308, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

      // Reset in the middle of traffic
      apply(1, 32'h400, 32'h00528333, 0, 0, 0, 0, 0);
      reset = 1;
      #1;
      chk("mid_rst_valid", 32'(id_valid), 32'd0);
      chk("mid_rst_pc", id_pc, RST_PC);
      chk("mid_rst_data", id_rs1_data, 32'd0);
      reset = 0;
      apply(1, 32'h404, 32'h00528333, 0, 0, 0, 0, 0);
      chk("rf_cleared", id_rs1_data, 32'd0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
